// File: rtl/main_fib_engine.sv
// Iterative Fibonacci kernel with a go/done handshake.
// A run computes F(N) mod 2^WIDTH in a fixed 2N+3 cycles from the go-sampling edge.
module main_fib_engine #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCond,
        StBody,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [31:0]        i_q, i_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               done_q, done_d;

    // Next-state and datapath updates for the iteration FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                a_d     = '0;
                b_d     = {{(WIDTH-1){1'b0}}, 1'b1};
                i_d     = '0;
                state_d = StCond;
            end
            StCond: begin
                if (i_q < N) begin
                    state_d = StBody;
                end else begin
                    out_d   = a_q;
                    state_d = StDone;
                end
            end
            StBody: begin
                a_d     = b_q;
                b_d     = a_q + b_q;  // wraps silently at WIDTH bits
                i_d     = i_q + 32'd1;
                state_d = StCond;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // done is registered so it is high exactly while the FSM sits in StDone.
        done_d = (state_d == StDone);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_main_fib_engine.sv
// Scoreboard bench for main_fib_engine: randomized go traffic on a default instance,
// plus directed runs on N=0, N=1 and WIDTH=8/N=14 instances.
module tb_main_fib_engine;

    localparam int unsigned MainN = 10;

    typedef struct {
        int unsigned done_edge;
        logic [31:0] value;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        go;
    logic        done;
    logic [31:0] out;

    logic        aux_go   [3];
    logic        aux_done [3];
    logic [31:0] aux_out  [3];
    logic [31:0] out_n0;
    logic [31:0] out_n1;
    logic [7:0]  out_w8;

    exp_t        q[$];
    int unsigned cyc;
    int unsigned next_free;
    int          checks;
    int          failures;
    logic [31:0] exp_out;

    main_fib_engine #(.WIDTH(32), .N(MainN)) u_dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .done  (done),
        .out   (out)
    );

    main_fib_engine #(.WIDTH(32), .N(0)) u_dut_n0 (
        .clk   (clk),
        .reset (reset),
        .go    (aux_go[0]),
        .done  (aux_done[0]),
        .out   (out_n0)
    );

    main_fib_engine #(.WIDTH(8), .N(14)) u_dut_w8 (
        .clk   (clk),
        .reset (reset),
        .go    (aux_go[1]),
        .done  (aux_done[1]),
        .out   (out_w8)
    );

    main_fib_engine #(.WIDTH(32), .N(1)) u_dut_n1 (
        .clk   (clk),
        .reset (reset),
        .go    (aux_go[2]),
        .done  (aux_done[2]),
        .out   (out_n1)
    );

    assign aux_out[0] = out_n0;
    assign aux_out[1] = {24'd0, out_w8};
    assign aux_out[2] = out_n1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: Fibonacci by plain iteration, reduced modulo 2^w.
    function automatic logic [31:0] fib(input int n, input int w);
        longint unsigned a, b, t, mask;
        mask = (64'd1 << w) - 64'd1;
        a = 0;
        b = 1;
        for (int k = 0; k < n; k++) begin
            t = (a + b) & mask;
            a = b;
            b = t;
        end
        return 32'(a & mask);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive go for the next edge; if the model says the DUT is idle there, predict a run.
    task automatic drive_main(input bit g);
        @(negedge clk);
        go = g;
        if (g && reset && (cyc + 1 >= next_free)) begin
            exp_t e;
            e.done_edge = cyc + 1 + 2 * MainN + 2;
            e.value     = fib(int'(MainN), 32);
            q.push_back(e);
            next_free = e.done_edge + 2;
        end
    endtask

    task automatic run_aux(input int idx, input int n, input int w);
        int unsigned e0;
        bit          seen;
        @(negedge clk);
        aux_go[idx] = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        aux_go[idx] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (aux_done[idx]) seen = 1'b1;
            else @(negedge clk);
        end
        chk("aux_done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("aux_latency", 64'(cyc - e0 + 1), 64'(2 * n + 3));
            chk("aux_out", 64'(aux_out[idx]), 64'(fib(n, w)));
            @(negedge clk);
            chk("aux_done_width", 64'(aux_done[idx]), 64'd0);
            chk("aux_out_hold", 64'(aux_out[idx]), 64'(fib(n, w)));
        end
    endtask

    // Monitor: done must appear exactly at predicted edges, out only changes there.
    always @(negedge clk) begin
        if (!reset) begin
            exp_out = '0;
            chk("reset_done", 64'(done), 64'd0);
            chk("reset_out", 64'(out), 64'd0);
        end else begin
            logic exp_done;
            exp_done = (q.size() > 0) && (q[0].done_edge == cyc);
            if (exp_done) begin
                exp_out = q[0].value;
                void'(q.pop_front());
            end
            chk("done", 64'(done), 64'(exp_done));
            chk("out", 64'(out), 64'(exp_out));
        end
    end

    initial begin
        int unsigned e0;
        int          bound;
        cyc       = 0;
        next_free = 0;
        checks    = 0;
        failures  = 0;
        exp_out   = '0;
        go        = 1'b0;
        for (int k = 0; k < 3; k++) aux_go[k] = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;

        // Idle with go low for a while.
        repeat (6) drive_main(1'b0);

        // go held high: done every 2N+4 cycles.
        repeat (80) drive_main(1'b1);
        repeat (30) drive_main(1'b0);

        // Single-cycle go pulse.
        drive_main(1'b1);
        repeat (40) drive_main(1'b0);

        // Random go traffic.
        repeat (300) drive_main($urandom_range(0, 3) == 0);
        repeat (30) drive_main(1'b0);

        // Asynchronous reset mid-run after edge 10.
        drive_main(1'b1);
        e0 = cyc + 1;
        while (cyc < e0 + 8) drive_main(1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        q.delete();
        next_free = 0;
        #1;
        chk("async_done", 64'(done), 64'd0);
        chk("async_out", 64'(out), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive_main(1'b1);
        repeat (30) drive_main(1'b0);

        // Directed runs on the other parameterisations.
        run_aux(0, 0, 32);
        run_aux(2, 1, 32);
        run_aux(1, 14, 8);

        // Drain any outstanding predictions.
        bound = 0;
        while (q.size() > 0 && bound < 200) begin
            drive_main(1'b0);
            bound++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
